// File: rtl/mem_stage_regs_if.sv
// SRAM-side bus of the DLX memory stage: word address, write data and write
// enable toward the SRAM, combinational read word back from it.
interface mem_stage_regs_if;
    // No handshake: a write commits on every cycle mem_we is high, and
    // mem_rdata is valid in the same cycle for whatever mem_addr shows.
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage_regs.sv
// DLX MEM stage: word/byte load extraction, byte read-modify-write stores,
// MEM/WB pipeline registers and the three-deep branch stall history.

module dff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_o <= 1'b0;
        else         q_o <= d_i;
    end
endmodule

module not_gate (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module and_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module mem_stage_regs (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             addr,
    input  logic [31:0]             din,
    input  logic                    we,
    input  logic                    store_byte,
    input  logic [1:0]              load_byte,
    mem_stage_regs_if.master        mem,
    input  logic                    MemtoReg_ex,
    input  logic                    RegWrite_ex,
    input  logic                    Branch_ex,
    input  logic                    init_delay,
    input  logic [4:0]              towrite_ex,
    output logic [31:0]             dout_mem,
    output logic [31:0]             dout,
    output logic [31:0]             result_mem,
    output logic                    MemtoReg_mem,
    output logic                    RegWrite_mem,
    output logic [4:0]              towrite_mem,
    output logic                    Branch_stall_forwarding
);
    logic [1:0]  lane;
    logic [31:0] rdata;
    logic [7:0]  lane_byte;
    logic [31:0] rmw_word;

    logic [31:0] dout_q;
    logic [31:0] result_q;
    logic        memtoreg_q;
    logic        regwrite_q;
    logic [4:0]  towrite_q;
    logic [2:0]  branch_d;
    logic [2:0]  branch_q;
    logic        any_branch;
    logic        init_n;

    assign lane  = addr[1:0];
    assign rdata = mem.mem_rdata;

    assign mem.mem_addr = addr & 32'hFFFF_FFFC;
    assign mem.mem_we   = we;

    // Big-endian lanes: lane 0 is the most significant byte of the word.
    always_comb begin
        lane_byte = 8'h00;
        rmw_word  = rdata;
        case (lane)
            2'd0: begin
                lane_byte       = rdata[31:24];
                rmw_word[31:24] = din[7:0];
            end
            2'd1: begin
                lane_byte       = rdata[23:16];
                rmw_word[23:16] = din[7:0];
            end
            2'd2: begin
                lane_byte       = rdata[15:8];
                rmw_word[15:8]  = din[7:0];
            end
            default: begin
                lane_byte       = rdata[7:0];
                rmw_word[7:0]   = din[7:0];
            end
        endcase
    end

    assign mem.mem_wdata = store_byte ? rmw_word : din;

    always_comb begin
        dout_mem = rdata;
        case (load_byte)
            2'b10:   dout_mem = {24'h000000, lane_byte};
            2'b01:   dout_mem = {{24{lane_byte[7]}}, lane_byte};
            default: dout_mem = rdata;
        endcase
    end

    for (genvar i = 0; i < 32; i++) begin : g_data_regs
        dff u_dout_dff (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .d_i    (dout_mem[i]),
            .q_o    (dout_q[i])
        );
        dff u_result_dff (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .d_i    (addr[i]),
            .q_o    (result_q[i])
        );
    end

    for (genvar i = 0; i < 5; i++) begin : g_towrite_regs
        dff u_towrite_dff (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .d_i    (towrite_ex[i]),
            .q_o    (towrite_q[i])
        );
    end

    dff u_memtoreg_dff (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (MemtoReg_ex),
        .q_o    (memtoreg_q)
    );

    dff u_regwrite_dff (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (RegWrite_ex),
        .q_o    (regwrite_q)
    );

    // Branch history B0 -> B1 -> B2; keeps shifting even while init_delay masks it.
    assign branch_d = {branch_q[1:0], Branch_ex};

    for (genvar i = 0; i < 3; i++) begin : g_branch_hist
        dff u_branch_dff (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .d_i    (branch_d[i]),
            .q_o    (branch_q[i])
        );
    end

    assign any_branch = |branch_q;

    not_gate u_init_not (
        .a_i (init_delay),
        .y_o (init_n)
    );

    and_gate u_stall_and (
        .a_i (any_branch),
        .b_i (init_n),
        .y_o (Branch_stall_forwarding)
    );

    assign dout         = dout_q;
    assign result_mem   = result_q;
    assign MemtoReg_mem = memtoreg_q;
    assign RegWrite_mem = regwrite_q;
    assign towrite_mem  = towrite_q;
endmodule

// File: tb/tb_mem_stage_regs.sv
// Directed bench for mem_stage_regs: load/store lane logic, MEM/WB registers,
// branch stall window, init_delay masking and asynchronous reset.
module tb_mem_stage_regs;
    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic        store_byte;
    logic [1:0]  load_byte;
    logic        MemtoReg_ex;
    logic        RegWrite_ex;
    logic        Branch_ex;
    logic        init_delay;
    logic [4:0]  towrite_ex;
    logic [31:0] dout_mem;
    logic [31:0] dout;
    logic [31:0] result_mem;
    logic        MemtoReg_mem;
    logic        RegWrite_mem;
    logic [4:0]  towrite_mem;
    logic        Branch_stall_forwarding;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_stage_regs_if mem_if ();

    mem_stage_regs dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .addr                    (addr),
        .din                     (din),
        .we                      (we),
        .store_byte              (store_byte),
        .load_byte               (load_byte),
        .mem                     (mem_if),
        .MemtoReg_ex             (MemtoReg_ex),
        .RegWrite_ex             (RegWrite_ex),
        .Branch_ex               (Branch_ex),
        .init_delay              (init_delay),
        .towrite_ex              (towrite_ex),
        .dout_mem                (dout_mem),
        .dout                    (dout),
        .result_mem              (result_mem),
        .MemtoReg_mem            (MemtoReg_mem),
        .RegWrite_mem            (RegWrite_mem),
        .towrite_mem             (towrite_mem),
        .Branch_stall_forwarding (Branch_stall_forwarding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        addr             = 32'h0;
        din              = 32'h0;
        we               = 1'b0;
        store_byte       = 1'b0;
        load_byte        = 2'b00;
        MemtoReg_ex      = 1'b0;
        RegWrite_ex      = 1'b0;
        Branch_ex        = 1'b0;
        init_delay       = 1'b0;
        towrite_ex       = 5'd0;
        mem_if.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        addr             = 32'hDEAD_BEEF;
        mem_if.mem_rdata = 32'h1234_5678;
        rst_n            = 1'b0;
        #2;
        checks++;
        if ({dout, result_mem, MemtoReg_mem, RegWrite_mem, towrite_mem, Branch_stall_forwarding} !== 71'h0) begin
            errors++;
            $display("FAIL reset_state got dout=%h result=%h m2r=%b rw=%b tw=%0d bsf=%b required all zero",
                     dout, result_mem, MemtoReg_mem, RegWrite_mem, towrite_mem, Branch_stall_forwarding);
        end
        checks++;
        if (dout_mem !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_comb_dout_mem got %h required 12345678", dout_mem);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_word_load();
        addr             = 32'h0000_0103;
        mem_if.mem_rdata = 32'h1122_3344;
        load_byte        = 2'b00;
        #1;
        checks++;
        if (mem_if.mem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL word_mem_addr got %h required 00000100", mem_if.mem_addr);
        end
        checks++;
        if (dout_mem !== 32'h1122_3344) begin
            errors++;
            $display("FAIL word_dout_mem got %h required 11223344", dout_mem);
        end
        load_byte = 2'b11;
        #1;
        checks++;
        if (dout_mem !== 32'h1122_3344) begin
            errors++;
            $display("FAIL word11_dout_mem got %h required 11223344", dout_mem);
        end
        load_byte = 2'b00;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 32'h1122_3344) begin
            errors++;
            $display("FAIL word_dout_reg got %h required 11223344", dout);
        end
        checks++;
        if (result_mem !== 32'h0000_0103) begin
            errors++;
            $display("FAIL word_result_mem got %h required 00000103", result_mem);
        end
        @(negedge clk);
    endtask

    task automatic test_byte_load();
        logic [1:0]  lanes [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        logic [1:0]  modes [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] exps  [6] = '{32'hFFFF_FF8A, 32'h0000_008A, 32'h0000_007F,
                                   32'h0000_007F, 32'h0000_0000, 32'h0000_0000};
        mem_if.mem_rdata = 32'h8A7F_0000;
        for (int i = 0; i < 6; i++) begin
            addr      = {30'h0000_0040, lanes[i]};
            load_byte = modes[i];
            #1;
            checks++;
            if (dout_mem !== exps[i]) begin
                errors++;
                $display("FAIL byte_load_%0d got %h required %h", i, dout_mem, exps[i]);
            end
        end
        mem_if.mem_rdata = 32'h0000_00F0;
        addr      = 32'h0000_0003;
        load_byte = 2'b01;
        #1;
        checks++;
        if (dout_mem !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL byte_load_lane3_signed got %h required fffffff0", dout_mem);
        end
        load_byte = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_byte_store();
        logic [31:0] exps [4] = '{32'h99BB_CCDD, 32'hAA99_CCDD, 32'hAABB_99DD, 32'hAABB_CC99};
        mem_if.mem_rdata = 32'hAABB_CCDD;
        din              = 32'h1234_5699;
        we               = 1'b1;
        store_byte       = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr = 32'h0000_0200 + k;
            #1;
            checks++;
            if (mem_if.mem_wdata !== exps[k]) begin
                errors++;
                $display("FAIL byte_store_lane%0d got %h required %h", k, mem_if.mem_wdata, exps[k]);
            end
        end
        addr = 32'h0000_0202;
        #1;
        checks++;
        if (mem_if.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL store_we got %b required 1", mem_if.mem_we);
        end
        store_byte = 1'b0;
        #1;
        checks++;
        if (mem_if.mem_wdata !== 32'h1234_5699) begin
            errors++;
            $display("FAIL word_store got %h required 12345699", mem_if.mem_wdata);
        end
        we = 1'b0;
        #1;
        checks++;
        if (mem_if.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL store_we_low got %b required 0", mem_if.mem_we);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_branch_stall();
        logic pattern [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        repeat (3) @(negedge clk);
        init_delay = 1'b0;
        Branch_ex  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            Branch_ex = 1'b0;
            checks++;
            if (Branch_stall_forwarding !== pattern[c]) begin
                errors++;
                $display("FAIL branch_stall_cycle%0d got %b required %b", c, Branch_stall_forwarding, pattern[c]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_branch_init_delay();
        init_delay = 1'b1;
        Branch_ex  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            Branch_ex = 1'b0;
            checks++;
            if (Branch_stall_forwarding !== 1'b0) begin
                errors++;
                $display("FAIL init_delay_mask_cycle%0d got %b required 0", c, Branch_stall_forwarding);
            end
        end
        // Fresh pulse, then lift init_delay between edges: history should show at once.
        @(negedge clk);
        Branch_ex = 1'b1;
        @(posedge clk);
        #1;
        Branch_ex  = 1'b0;
        init_delay = 1'b0;
        #1;
        checks++;
        if (Branch_stall_forwarding !== 1'b1) begin
            errors++;
            $display("FAIL init_delay_release got %b required 1", Branch_stall_forwarding);
        end
        init_delay = 1'b1;
        #1;
        checks++;
        if (Branch_stall_forwarding !== 1'b0) begin
            errors++;
            $display("FAIL init_delay_reassert got %b required 0", Branch_stall_forwarding);
        end
        init_delay = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_control_pipe();
        MemtoReg_ex = 1'b1;
        RegWrite_ex = 1'b1;
        towrite_ex  = 5'd17;
        @(posedge clk);
        #1;
        checks++;
        if ({MemtoReg_mem, RegWrite_mem, towrite_mem} !== {1'b1, 1'b1, 5'd17}) begin
            errors++;
            $display("FAIL control_pipe got m2r=%b rw=%b tw=%0d required 1 1 17",
                     MemtoReg_mem, RegWrite_mem, towrite_mem);
        end
        MemtoReg_ex = 1'b0;
        towrite_ex  = 5'd3;
        @(posedge clk);
        #1;
        checks++;
        if ({MemtoReg_mem, RegWrite_mem, towrite_mem} !== {1'b0, 1'b1, 5'd3}) begin
            errors++;
            $display("FAIL control_pipe2 got m2r=%b rw=%b tw=%0d required 0 1 3",
                     MemtoReg_mem, RegWrite_mem, towrite_mem);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h0000_0004, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0000};
        logic [31:0] got;
        for (int i = 0; i < 4; i++) begin
            addr = addrs[i];
            exp_q.push_back(addrs[i]);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            checks++;
            if (result_mem !== got) begin
                errors++;
                $display("FAIL back_to_back_%0d got %h required %h", i, result_mem, got);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        addr             = 32'h0000_0055;
        mem_if.mem_rdata = 32'hCAFE_F00D;
        MemtoReg_ex      = 1'b1;
        RegWrite_ex      = 1'b1;
        towrite_ex       = 5'd9;
        Branch_ex        = 1'b1;
        @(posedge clk);
        #1;
        Branch_ex = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (Branch_stall_forwarding !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall got %b required 1", Branch_stall_forwarding);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, result_mem, MemtoReg_mem, RegWrite_mem, towrite_mem, Branch_stall_forwarding} !== 71'h0) begin
            errors++;
            $display("FAIL mid_reset got dout=%h result=%h m2r=%b rw=%b tw=%0d bsf=%b required all zero",
                     dout, result_mem, MemtoReg_mem, RegWrite_mem, towrite_mem, Branch_stall_forwarding);
        end
        checks++;
        if (mem_if.mem_addr !== 32'h0000_0054) begin
            errors++;
            $display("FAIL mid_reset_mem_addr got %h required 00000054", mem_if.mem_addr);
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({dout, result_mem, MemtoReg_mem, RegWrite_mem, towrite_mem, Branch_stall_forwarding} !== 71'h0) begin
                errors++;
                $display("FAIL post_reset_cycle%0d got dout=%h result=%h m2r=%b rw=%b tw=%0d bsf=%b required all zero",
                         c, dout, result_mem, MemtoReg_mem, RegWrite_mem, towrite_mem, Branch_stall_forwarding);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_branch_stall();
        test_branch_init_delay();
        test_control_pipe();
        test_back_to_back();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
